pool_event_serializer: RTL and testbench
========================================

# pool_event_serializer

Downstream stage of the sum-pooling block in the convolution pipeline. Accepts packed pooled-window spike vectors (timestep flag, halved x/y, one spike bit per channel) and buffers them in a small FIFO. Serializes each vector into one address-event per set channel bit over a valid/ready interface. Optionally emits a timestep marker event after the last event of a flagged vector.

## Interface
- `OUT_CHANNELS`, default 4: spike bits per input vector.
- `BITS_PER_COORDINATE`, default 6: upstream coordinate width. Event x/y fields are `BITS_PER_COORDINATE-1` bits wide.
- `FIFO_DEPTH`, default 4: input FIFO entries. Must be a power of two and at least 2.
- `IN_VECTOR_WIDTH`, default `(BITS_PER_COORDINATE-1)*2+OUT_CHANNELS+1`: packed input width.
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: `in_vector` is valid this cycle.
- `in_vector`, in, `IN_VECTOR_WIDTH`: packed as {timestep, x, y, spikes}, with spikes in the LSBs.
- `in_ready`, out, 1: high when the FIFO is not full.
- `event_valid`, out, 1: an event is presented.
- `event_ready`, in, 1: the consumer accepts the event.
- `event_x`, out, `BITS_PER_COORDINATE-1`: window x.
- `event_y`, out, `BITS_PER_COORDINATE-1`: window y.
- `event_channel`, out, `$clog2(OUT_CHANNELS)`: index of the spiking channel.
- `event_timestep`, out, 1: marks a timestep marker event.
- `overflow`, out, 1: sticky flag; a vector was dropped because the FIFO was full.
- `busy`, out, 1: high when the FSM is not in IDLE or the FIFO is non-empty.

## Operation
- **Write side.** A vector is written on any edge where `in_valid` is high and the FIFO is not full.
  - If `in_valid` is high while the FIFO is full, the vector is dropped and `overflow` is set to 1. It holds until reset.
  - Full is evaluated before any same-cycle pop: a full FIFO refuses a push even if it pops in that cycle.
- **FSM states:** IDLE, EMIT, MARK.
- **IDLE.**
  - If the FIFO is non-empty, pop the head into the holding register (ts, x, y, pend = spikes).
  - If the popped spikes are non-zero, go to EMIT.
  - Else if ts = 1, go to MARK.
  - Else stay in IDLE; the vector is discarded.
- **EMIT.**
  - `event_valid` = 1, `event_channel` = index of the lowest set bit of pend, `event_timestep` = 0.
  - On handshake (`event_valid && event_ready`), clear that bit.
  - If that was the last set bit: go to MARK if ts = 1, else go to IDLE.
- **MARK.**
  - `event_valid` = 1, `event_timestep` = 1, `event_channel` = 0, x/y taken from the holding register.
  - On handshake, go to IDLE.
- **Backpressure.** While `event_valid && !event_ready`, all `event_*` fields are held stable.
- **Return to IDLE.** The FSM always passes through IDLE between vectors, so each new vector costs one pop cycle.
- **Mid-operation reset.** The FIFO and holding register are cleared immediately and in-flight events are lost.

## Timing
- **Reset values:** `event_valid` = 0, `event_x` = `event_y` = `event_channel` = `event_timestep` = 0, `overflow` = 0, `busy` = 0, `in_ready` = 1, FSM in IDLE, FIFO empty.
- **Latency.** A vector written at edge N is popped at edge N+1. `event_valid` is first high in the cycle after edge N+1.
- **Throughput.** One event per cycle while `event_ready` = 1. Each vector costs 1 pop cycle plus popcount(spikes) cycles, plus 1 cycle if a marker is emitted.
- **Capacity.** FIFO pointers carry an extra wrap bit: empty when the pointers are equal, full when they differ only in the MSB. Effective buffering is `FIFO_DEPTH` + 1 vectors, counting the holding register.
- **Output sourcing.** `event_channel` is driven by a priority encoder on the registered pend. All other outputs come directly from registers.

## Configuration
- Macro: `POOL_SERIALIZER_TIMESTEP_MARKER_EN`.
- **Defined:** MARK state exists and behaves as described above.
- **Undefined:**
  - MARK is not compiled.
  - `event_timestep` is tied to 0.
  - The ts bit is ignored, so vectors with spikes = 0 are always discarded in IDLE.
  - After the last EMIT handshake the FSM goes to IDLE.

## Structure
- **Shared package `conv_pkg`:** the output vector struct {timestep, x, y, spikes} and its width function, shared with sum pooling, plus the FSM state enum.
- **Sub-module `event_fifo`:** a generic synchronous FIFO with parameters WIDTH and DEPTH, asynchronous active-low reset, and push/pop/full/empty ports.

## Test plan
Bench configuration: `OUT_CHANNELS` = 4, `BITS_PER_COORDINATE` = 6, `FIFO_DEPTH` = 4.
1. Push {ts=0, x=3, y=7, spikes=4'b1010} with `event_ready` = 1 → events ch1 then ch3 at (3,7) in consecutive cycles; first `event_valid` in the cycle after edge N+1; no marker.
2. Same vector, `event_ready` held at 0 for 3 cycles → ch1/x=3/y=7 stable for those 3 cycles; ch3 follows after `event_ready` rises.
3. Push {ts=1, x=5, y=2, spikes=0} → macro defined: one event with `event_timestep` = 1, ch0, (5,2). Macro undefined: no event and `busy` returns to 0.
4. Push {ts=1, x=0, y=0, spikes=4'b1111} → channels 0, 1, 2, 3 then a marker: 5 handshakes on consecutive cycles.
5. With `event_ready` = 0, push 6 vectors on consecutive edges → vectors 1–5 accepted (1 held, 4 in the FIFO); 6th dropped with `in_ready` = 0; `overflow` = 1 and stays 1.
6. Assert `reset` low during EMIT of a 4'b1111 vector → `event_valid` = 0 and `busy` = 0 immediately; after release, a new vector is serialized correctly with no stale events.

Source files
------------

// File: rtl/conv_pkg.sv
// Types shared across the convolution pipeline: pooled output vector layout,
// its packed width, and the event serializer FSM encoding.
package conv_pkg;

    localparam int CONV_OUT_CHANNELS        = 4;
    localparam int CONV_BITS_PER_COORDINATE = 6;
    localparam int CONV_COORD_WIDTH         = CONV_BITS_PER_COORDINATE - 1;

    // Pooled window vector as produced by sum pooling; spikes occupy the LSBs.
    typedef struct packed {
        logic                         timestep;
        logic [CONV_COORD_WIDTH-1:0]  x;
        logic [CONV_COORD_WIDTH-1:0]  y;
        logic [CONV_OUT_CHANNELS-1:0] spikes;
    } pool_vector_t;

    function automatic int pool_vector_width(input int out_channels,
                                             input int bits_per_coordinate);
        return (bits_per_coordinate - 1) * 2 + out_channels + 1;
    endfunction

    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_EMIT = 2'd1;
    localparam logic [1:0] STATE_MARK = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = STATE_IDLE,
        ST_EMIT = STATE_EMIT,
        ST_MARK = STATE_MARK
    } ser_state_e;

endpackage

// File: rtl/event_fifo.sv
// Generic first-word-fall-through FIFO; head entry is visible on pop_data
// whenever empty is low. Pointers carry one extra wrap bit.
module event_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Full is judged on the registered pointers, so a same-cycle pop never frees a slot for a push.
    assign full    = (wr_ptr_reg ^ rd_ptr_reg) == {1'b1, {AW{1'b0}}};
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/pool_event_serializer.sv
// Buffers pooled spike vectors and serializes them into one address-event per
// set channel bit. POOL_SERIALIZER_TIMESTEP_MARKER_EN adds a trailing timestep marker.
module pool_event_serializer
    import conv_pkg::*;
#(
    parameter int OUT_CHANNELS        = 4,
    parameter int BITS_PER_COORDINATE = 6,
    parameter int FIFO_DEPTH          = 4,
    parameter int IN_VECTOR_WIDTH     = pool_vector_width(OUT_CHANNELS, BITS_PER_COORDINATE)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    input  logic [IN_VECTOR_WIDTH-1:0]        in_vector,
    output logic                              in_ready,
    output logic                              event_valid,
    input  logic                              event_ready,
    output logic [BITS_PER_COORDINATE-2:0]    event_x,
    output logic [BITS_PER_COORDINATE-2:0]    event_y,
    output logic [$clog2(OUT_CHANNELS)-1:0]   event_channel,
    output logic                              event_timestep,
    output logic                              overflow,
    output logic                              busy
);

    localparam int CW   = BITS_PER_COORDINATE - 1;
    localparam int CH_W = $clog2(OUT_CHANNELS);

    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       fifo_pop;
    logic [IN_VECTOR_WIDTH-1:0] head;
    logic                       head_ts;
    logic [CW-1:0]              head_x;
    logic [CW-1:0]              head_y;
    logic [OUT_CHANNELS-1:0]    head_spikes;

    ser_state_e                 state_reg, state_next;
    logic [CW-1:0]              x_reg, x_next;
    logic [CW-1:0]              y_reg, y_next;
    logic [OUT_CHANNELS-1:0]    pend_reg, pend_next;
    logic                       valid_reg, valid_next;
    logic                       overflow_reg, overflow_next;
    logic [OUT_CHANNELS-1:0]    low_onehot;
    logic [OUT_CHANNELS-1:0]    pend_remaining;
    logic                       handshake;

    event_fifo #(
        .WIDTH (IN_VECTOR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_valid),
        .pop       (fifo_pop),
        .push_data (in_vector),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign {head_ts, head_x, head_y, head_spikes} = head;

    assign in_ready      = !fifo_full;
    assign overflow_next = overflow_reg | (in_valid & fifo_full);

    // Isolate the lowest pending channel; the encoder ORs the indices of the set one-hot bit.
    assign low_onehot     = pend_reg & (~pend_reg + {{(OUT_CHANNELS-1){1'b0}}, 1'b1});
    assign pend_remaining = pend_reg & ~low_onehot;
    assign handshake      = valid_reg && event_ready;

    genvar gi, gc;
    generate
        for (gi = 0; gi < CH_W; gi++) begin : g_chan_enc
            logic [OUT_CHANNELS-1:0] sel_mask;
            for (gc = 0; gc < OUT_CHANNELS; gc++) begin : g_mask
                assign sel_mask[gc] = 1'(((gc >> gi) & 1) == 1);
            end
            assign event_channel[gi] = |(low_onehot & sel_mask);
        end
    endgenerate

`ifdef POOL_SERIALIZER_TIMESTEP_MARKER_EN
    logic ts_reg, ts_next;
    logic mark_reg, mark_next;
`else
    logic unused_ts;
    assign unused_ts = head_ts;
`endif

    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        pend_next  = pend_reg;
        valid_next = valid_reg;
        fifo_pop   = 1'b0;
`ifdef POOL_SERIALIZER_TIMESTEP_MARKER_EN
        ts_next    = ts_reg;
        mark_next  = mark_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    x_next    = head_x;
                    y_next    = head_y;
                    pend_next = head_spikes;
`ifdef POOL_SERIALIZER_TIMESTEP_MARKER_EN
                    ts_next   = head_ts;
                    if (head_spikes != '0) begin
                        state_next = ST_EMIT;
                        valid_next = 1'b1;
                    end else if (head_ts) begin
                        state_next = ST_MARK;
                        valid_next = 1'b1;
                        mark_next  = 1'b1;
                    end
`else
                    if (head_spikes != '0) begin
                        state_next = ST_EMIT;
                        valid_next = 1'b1;
                    end
`endif
                end
            end
            ST_EMIT: begin
                if (handshake) begin
                    pend_next = pend_remaining;
                    if (pend_remaining == '0) begin
`ifdef POOL_SERIALIZER_TIMESTEP_MARKER_EN
                        if (ts_reg) begin
                            state_next = ST_MARK;
                            mark_next  = 1'b1;
                        end else begin
                            state_next = ST_IDLE;
                            valid_next = 1'b0;
                        end
`else
                        state_next = ST_IDLE;
                        valid_next = 1'b0;
`endif
                    end
                end
            end
`ifdef POOL_SERIALIZER_TIMESTEP_MARKER_EN
            ST_MARK: begin
                if (handshake) begin
                    state_next = ST_IDLE;
                    valid_next = 1'b0;
                    mark_next  = 1'b0;
                end
            end
`endif
            default: begin
                state_next = ST_IDLE;
                valid_next = 1'b0;
                pend_next  = '0;
`ifdef POOL_SERIALIZER_TIMESTEP_MARKER_EN
                mark_next  = 1'b0;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            x_reg        <= '0;
            y_reg        <= '0;
            pend_reg     <= '0;
            valid_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            x_reg        <= x_next;
            y_reg        <= y_next;
            pend_reg     <= pend_next;
            valid_reg    <= valid_next;
            overflow_reg <= overflow_next;
        end
    end

`ifdef POOL_SERIALIZER_TIMESTEP_MARKER_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_reg   <= 1'b0;
            mark_reg <= 1'b0;
        end else begin
            ts_reg   <= ts_next;
            mark_reg <= mark_next;
        end
    end
    assign event_timestep = mark_reg;
`else
    assign event_timestep = 1'b0;
`endif

    assign event_valid = valid_reg;
    assign event_x     = x_reg;
    assign event_y     = y_reg;
    assign overflow    = overflow_reg;
    assign busy        = (state_reg != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_pool_event_serializer.sv
// Directed and randomized bench for pool_event_serializer; expected events come
// from a per-vector expansion model. Honors POOL_SERIALIZER_TIMESTEP_MARKER_EN.
`timescale 1ns/1ps
module tb_pool_event_serializer;
    import conv_pkg::*;

    localparam int OC    = 4;
    localparam int BPC   = 6;
    localparam int DEPTH = 4;
    localparam int IW    = (BPC - 1) * 2 + OC + 1;
`ifdef POOL_SERIALIZER_TIMESTEP_MARKER_EN
    localparam bit MARKER_EN = 1'b1;
`else
    localparam bit MARKER_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [IW-1:0] in_vector = '0;
    logic          in_ready;
    logic          event_valid;
    logic          event_ready = 1'b0;
    logic [4:0]    event_x;
    logic [4:0]    event_y;
    logic [1:0]    event_channel;
    logic          event_timestep;
    logic          overflow;
    logic          busy;

    typedef struct packed {
        logic [4:0] x;
        logic [4:0] y;
        logic [1:0] ch;
        logic       ts;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  checks = 0;
    int  errors = 0;

    pool_event_serializer #(
        .OUT_CHANNELS        (OC),
        .BITS_PER_COORDINATE (BPC),
        .FIFO_DEPTH          (DEPTH),
        .IN_VECTOR_WIDTH     (IW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_vector      (in_vector),
        .in_ready       (in_ready),
        .event_valid    (event_valid),
        .event_ready    (event_ready),
        .event_x        (event_x),
        .event_y        (event_y),
        .event_channel  (event_channel),
        .event_timestep (event_timestep),
        .overflow       (overflow),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Inputs change just after posedge, so valid/ready at negedge predict the next edge's handshake.
    always @(negedge clk) begin
        if (reset && event_valid && event_ready) begin
            obs_q.push_back('{event_x, event_y, event_channel, event_timestep});
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IW-1:0] make_vec(input logic ts, input logic [4:0] x,
                                               input logic [4:0] y, input logic [3:0] sp);
        pool_vector_t pv;
        pv.timestep = ts;
        pv.x        = x;
        pv.y        = y;
        pv.spikes   = sp;
        return pv;
    endfunction

    // Reference: one event per set spike bit in ascending order, then an optional marker.
    task automatic model_add(input logic [IW-1:0] v);
        pool_vector_t pv;
        pv = v;
        for (int c = 0; c < OC; c++) begin
            if (pv.spikes[c]) exp_q.push_back('{pv.x, pv.y, 2'(c), 1'b0});
        end
        if (pv.timestep && MARKER_EN) exp_q.push_back('{pv.x, pv.y, 2'd0, 1'b1});
    endtask

    task automatic push(input logic [IW-1:0] v);
        in_valid  = 1'b1;
        in_vector = v;
        model_add(v);
        @(posedge clk); #1;
        in_valid  = 1'b0;
    endtask

    task automatic next_neg();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic compare_queues(input string tag);
        int n;
        n = 0;
        event_ready = 1'b1;
        while ((busy || obs_q.size() != exp_q.size()) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_drain"}, 32'(n < 1000), 32'd1);
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            $display("%s event %0d: x=%0d y=%0d ch=%0d ts=%0d", tag, i,
                     obs_q[i].x, obs_q[i].y, obs_q[i].ch, obs_q[i].ts);
            check({tag, "_event"}, 32'(obs_q[i]), 32'(exp_q[i]));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [IW-1:0] v;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", event_valid, 0);
        check("rst_x", event_x, 0);
        check("rst_y", event_y, 0);
        check("rst_ch", event_channel, 0);
        check("rst_ts", event_timestep, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // 1: two events back to back, first valid one cycle after the pop edge
        event_ready = 1'b1;
        push(make_vec(1'b0, 5'd3, 5'd7, 4'b1010));
        @(negedge clk);
        check("t1_latency_valid", event_valid, 0);
        next_neg();
        check("t1_e0_valid", event_valid, 1);
        check("t1_e0_ch", event_channel, 1);
        check("t1_e0_x", event_x, 3);
        check("t1_e0_y", event_y, 7);
        check("t1_e0_ts", event_timestep, 0);
        next_neg();
        check("t1_e1_valid", event_valid, 1);
        check("t1_e1_ch", event_channel, 3);
        next_neg();
        check("t1_done_valid", event_valid, 0);
        check("t1_done_busy", busy, 0);
        @(posedge clk); #1;
        compare_queues("t1");

        // 2: backpressure holds the first event stable
        event_ready = 1'b0;
        push(make_vec(1'b0, 5'd3, 5'd7, 4'b1010));
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            next_neg();
            check("t2_hold_valid", event_valid, 1);
            check("t2_hold_ch", event_channel, 1);
            check("t2_hold_x", event_x, 3);
            check("t2_hold_y", event_y, 7);
        end
        @(posedge clk); #1;
        event_ready = 1'b1;
        @(negedge clk);
        check("t2_release_ch", event_channel, 1);
        next_neg();
        check("t2_second_ch", event_channel, 3);
        check("t2_second_valid", event_valid, 1);
        next_neg();
        check("t2_done_valid", event_valid, 0);
        @(posedge clk); #1;
        compare_queues("t2");

        // 3: empty spikes with timestep flag
        push(make_vec(1'b1, 5'd5, 5'd2, 4'b0000));
        @(negedge clk);
        next_neg();
        check("t3_valid", event_valid, MARKER_EN);
        check("t3_ts", event_timestep, MARKER_EN);
        check("t3_ch", event_channel, 0);
        check("t3_x", event_x, 5);
        check("t3_y", event_y, 2);
        next_neg();
        check("t3_end_valid", event_valid, 0);
        check("t3_end_busy", busy, 0);
        @(posedge clk); #1;
        compare_queues("t3");

        // 4: all channels then marker on consecutive cycles
        push(make_vec(1'b1, 5'd0, 5'd0, 4'b1111));
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            next_neg();
            check("t4_valid", event_valid, 1);
            check("t4_ch", event_channel, k);
            check("t4_ts", event_timestep, 0);
        end
        next_neg();
        check("t4_marker_valid", event_valid, MARKER_EN);
        check("t4_marker_ts", event_timestep, MARKER_EN);
        check("t4_marker_ch", event_channel, 0);
        next_neg();
        check("t4_end_valid", event_valid, 0);
        @(posedge clk); #1;
        compare_queues("t4");

        // 5: fill holding register plus FIFO, sixth vector dropped
        event_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            v = make_vec(1'($urandom), 5'($urandom), 5'($urandom), 4'($urandom_range(1, 15)));
            check("t5_in_ready", in_ready, 32'(i < 5));
            check("t5_overflow_pre", overflow, 0);
            in_valid  = 1'b1;
            in_vector = v;
            if (i < 5) model_add(v);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("t5_overflow_set", overflow, 1);
        check("t5_full_in_ready", in_ready, 0);
        @(posedge clk); #1;
        compare_queues("t5");
        check("t5_overflow_sticky", overflow, 1);

        // Random traffic with random consumer stalls
        for (int i = 0; i < 80; i++) begin
            event_ready = ($urandom_range(0, 3) != 0);
            if (in_ready && $urandom_range(0, 1) == 1) begin
                v = make_vec(1'($urandom), 5'($urandom), 5'($urandom), 4'($urandom));
                in_valid  = 1'b1;
                in_vector = v;
                model_add(v);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        compare_queues("rand");
        check("rand_overflow_sticky", overflow, 1);

        // 6: reset in the middle of an emission
        event_ready = 1'b0;
        push(make_vec(1'b0, 5'd9, 5'd4, 4'b1111));
        @(negedge clk);
        next_neg();
        check("t6_pre_valid", event_valid, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("t6_rst_valid", event_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_in_ready", in_ready, 1);
        check("t6_rst_overflow", overflow, 0);
        check("t6_rst_ch", event_channel, 0);
        check("t6_rst_x", event_x, 0);
        obs_q.delete();
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        event_ready = 1'b1;
        push(make_vec(1'($urandom), 5'($urandom), 5'($urandom), 4'($urandom_range(1, 15))));
        compare_queues("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
